lfsr_stream: RTL and testbench
==============================

// Module: lfsr_stream
// PURPOSE
//  Parametrised maximal-length LFSR pattern source with seed load, start/stop control and a
//  valid/ready output stream. Width and Fibonacci/Galois form are set at build time.
//  Wrap detection counts steps since the last seed. Feeds PRBS data to link/BIST datapaths.
//  Also acts as the reference generator for a future PRBS checker.
// PARAMETERS
//  N       8   state width, 3..32; taps come from lfsr_pkg::lfsr_taps(N) (XAPP 052 table 3)
//  GALOIS  0   0 = Fibonacci (external XOR), 1 = Galois (internal XOR), same tap set
// PORTS
//  clk          in   1  single clock, rising edge
//  rst          in   1  asynchronous, active-high reset
//  seed_data    in   N  seed value, bit 1 = MSB ... bit N = LSB, [1:N] order
//  seed_valid   in   1  seed offered
//  seed_ready   out  1  seed accepted when seed_valid && seed_ready
//  start        in   1  level/pulse; IDLE -> RUN
//  stop         in   1  level/pulse; request return to IDLE
//  out_data     out  N  current LFSR state
//  out_valid    out  1  out_data valid
//  out_ready    in   1  consumer ready; beat = out_valid && out_ready
//  wrap         out  1  1-cycle pulse: the stepped-to state equals the stored seed
//  step_cnt     out  N  beats since last seed or wrap
//  seed_err     out  1  sticky: last seed was zero and was replaced by 1
// BEHAVIOUR
//  Reset (async, immediate): state=1 (z[N]=1), seed_reg=1, FSM=IDLE, out_valid=0, wrap=0,
//   step_cnt=0, seed_err=0, seed_ready=1.
//  Fibonacci step: fb = XOR of z[t] for every tap t; z_nxt = {fb, z[1:N-1]}.
//  Galois step: out = z[N]; z_nxt = {out, z[1:N-1]} ^ (out ? tapmask shifted right by 1 : 0).
//  FSM states IDLE / RUN / STOP; seed_ready = (FSM==IDLE); out_valid = (FSM!=IDLE).
//  Seed load, IDLE only:
//   - a seed handshake sets state and seed_reg to seed_data and clears step_cnt.
//   - seed_data==0 loads 1 and sets seed_err; a nonzero seed clears seed_err.
//   - an all-zero state is therefore unreachable.
//  IDLE:
//   - start -> RUN. Seed and start in the same cycle: load the seed, enter RUN;
//     the first beat is the new seed.
//   - stop in IDLE is ignored.
//  RUN/STOP:
//   - out_data = state, registered, no combinational path from out_ready.
//   - Beat: state<=z_nxt, step_cnt+1.
//   - If z_nxt==seed_reg: wrap=1 for one cycle and step_cnt<=0.
//   - No beat: state, out_data and step_cnt hold (valid/data stable under backpressure).
//  RUN + stop:
//   - stop with a beat in the same cycle -> IDLE.
//   - stop without a beat -> STOP.
//  STOP:
//   - out_valid stays 1 until a beat, then -> IDLE.
//   - start and stop are ignored in STOP.
//  State is kept in IDLE; a later start resumes the sequence where it stopped.
//  step_cnt width N: a maximal sequence wraps at 2^N-1 beats, so step_cnt never overflows.
//  Latency: start -> out_valid 1 cycle; beat -> next out_data 1 cycle; wrap is coincident
//   with the new state.
// STRUCTURE
//  lfsr_pkg:
//   - function lfsr_taps(int n) returns a [1:32] tap mask for n = 3..32.
//   - localparams for the FSM encoding (S_IDLE, S_RUN, S_STOP).
//  Sub-module lfsr_step (combinational, parameters N/GALOIS/TAPS): state -> z_nxt.
//   The future checker reuses it.
//  Top: FSM, state/seed registers, step counter, wrap compare.
// TESTING
//  1 N=8, GALOIS=0, reset, start, out_ready=1 -> out_data 0x01,0x80,0x40,0x20,0x10,0x88.
//  2 N=8, both modes, free-run from seed 0x01:
//    -> wrap after exactly 255 beats, step_cnt returns to 0, no repeated state before wrap.
//  3 Hold out_ready=0 for 5 cycles mid-run -> out_data and out_valid unchanged;
//    the next beat resumes the sequence.
//  4 Seed 0x00 in IDLE -> state=0x01, seed_err=1.
//    Then seed 0xA5 -> seed_err=0, first beat 0xA5, wrap after 255 beats.
//  5 stop with out_ready=0 -> STOP with out_valid=1; stop with ready=1 -> IDLE.
//    seed_ready=0 until IDLE; a later start resumes the next state.
//  6 Assert rst mid-run with out_valid=1 -> outputs take reset values without a clock edge;
//    seed_ready=1.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR pattern source: FSM encoding and the
// maximal-length tap table (Xilinx XAPP 052, table 3), indexed [1:32].
package lfsr_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STOP = 2'd2
    } fsm_e;

    // Unused tap slots are passed as 0.
    function automatic logic [1:32] tap_set(input int a, input int b, input int c, input int d);
        logic [1:32] m;
        m = '0;
        m = m | (32'h8000_0000 >> (a - 1));
        m = m | (32'h8000_0000 >> (b - 1));
        if (c != 0) m = m | (32'h8000_0000 >> (c - 1));
        if (d != 0) m = m | (32'h8000_0000 >> (d - 1));
        return m;
    endfunction

    function automatic logic [1:32] lfsr_taps(input int n);
        case (n)
            3:       return tap_set(3, 2, 0, 0);
            4:       return tap_set(4, 3, 0, 0);
            5:       return tap_set(5, 3, 0, 0);
            6:       return tap_set(6, 5, 0, 0);
            7:       return tap_set(7, 6, 0, 0);
            8:       return tap_set(8, 6, 5, 4);
            9:       return tap_set(9, 5, 0, 0);
            10:      return tap_set(10, 7, 0, 0);
            11:      return tap_set(11, 9, 0, 0);
            12:      return tap_set(12, 6, 4, 1);
            13:      return tap_set(13, 4, 3, 1);
            14:      return tap_set(14, 5, 3, 1);
            15:      return tap_set(15, 14, 0, 0);
            16:      return tap_set(16, 15, 13, 4);
            17:      return tap_set(17, 14, 0, 0);
            18:      return tap_set(18, 11, 0, 0);
            19:      return tap_set(19, 6, 2, 1);
            20:      return tap_set(20, 17, 0, 0);
            21:      return tap_set(21, 19, 0, 0);
            22:      return tap_set(22, 21, 0, 0);
            23:      return tap_set(23, 18, 0, 0);
            24:      return tap_set(24, 23, 22, 17);
            25:      return tap_set(25, 22, 0, 0);
            26:      return tap_set(26, 6, 2, 1);
            27:      return tap_set(27, 5, 2, 1);
            28:      return tap_set(28, 25, 0, 0);
            29:      return tap_set(29, 27, 0, 0);
            30:      return tap_set(30, 6, 4, 1);
            31:      return tap_set(31, 28, 0, 0);
            32:      return tap_set(32, 22, 2, 1);
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/lfsr_stream_if.sv
// Seed, control and output-stream bundle of the LFSR pattern source.
// master = consumer/controller side, slave = the generator.
interface lfsr_stream_if #(
    parameter int N = 8
);
    import lfsr_pkg::*;

    // Both channels are strict valid/ready: a transfer happens on a rising clk edge
    // where valid && ready; the offering side holds valid and data stable until then,
    // and neither ready depends combinationally on the other side's valid.
    logic [1:N]   seed_data;
    logic         seed_valid;
    logic         seed_ready;
    logic         start;
    logic         stop;
    logic [1:N]   out_data;
    logic         out_valid;
    logic         out_ready;
    logic         wrap;
    logic [N-1:0] step_cnt;
    logic         seed_err;
    fsm_e         fsm_state;

    modport master (
        output seed_data, seed_valid, start, stop, out_ready,
        input  seed_ready, out_data, out_valid, wrap, step_cnt, seed_err, fsm_state
    );

    modport slave (
        input  seed_data, seed_valid, start, stop, out_ready,
        output seed_ready, out_data, out_valid, wrap, step_cnt, seed_err, fsm_state
    );

endinterface

// File: rtl/lfsr_step.sv
// One combinational LFSR step, state [1:N] (bit 1 = MSB). Shared by the
// generator and the future PRBS checker.
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int          N      = 8,
    parameter int          GALOIS = 0,
    parameter logic [1:32] TAPS   = lfsr_taps(N)
) (
    input  logic [1:N] z,
    output logic [1:N] z_nxt
);

    localparam logic [1:N] MASK = TAPS[1:N];

    generate
        if (GALOIS != 0) begin : g_galois
            // Tap t feeds position t+1, so the mask moves one place toward the LSB.
            localparam logic [1:N] SHIFTED = {1'b0, MASK[1:N-1]};
            assign z_nxt = {z[N], z[1:N-1]} ^ (z[N] ? SHIFTED : '0);
        end else begin : g_fib
            assign z_nxt = {^(z & MASK), z[1:N-1]};
        end
    endgenerate

endmodule

// File: rtl/lfsr_stream.sv
// Maximal-length LFSR pattern source: seed load in IDLE, start/stop control,
// valid/ready output stream, wrap detection and step counting.
module lfsr_stream
    import lfsr_pkg::*;
#(
    parameter int N      = 8,
    parameter int GALOIS = 0
) (
    input  logic          clk,
    input  logic          rst,
    lfsr_stream_if.slave  bus
);

    localparam logic [1:N]   ONE     = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] CNT_ONE = {{(N-1){1'b0}}, 1'b1};

    fsm_e         state_q;
    fsm_e         state_d;
    logic [1:N]   z_q;
    logic [1:N]   z_nxt;
    logic [1:N]   seed_q;
    logic [1:N]   seed_load;
    logic [N-1:0] cnt_q;
    logic         wrap_q;
    logic         err_q;
    logic         seed_zero;
    logic         seed_hs;
    logic         beat;

    lfsr_step #(.N(N), .GALOIS(GALOIS)) u_step (
        .z     (z_q),
        .z_nxt (z_nxt)
    );

    assign seed_hs   = bus.seed_valid && (state_q == S_IDLE);
    assign beat      = bus.out_ready && (state_q != S_IDLE);
    assign seed_zero = (bus.seed_data == '0);
    // The all-zero state would lock up, so a zero seed becomes 1.
    assign seed_load = seed_zero ? ONE : bus.seed_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_RUN;
            S_RUN:   if (bus.stop) state_d = beat ? S_IDLE : S_STOP;
            S_STOP:  if (beat) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_q    <= ONE;
            seed_q <= ONE;
            cnt_q  <= '0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            if (seed_hs) begin
                z_q    <= seed_load;
                seed_q <= seed_load;
                cnt_q  <= '0;
                err_q  <= seed_zero;
            end else if (beat) begin
                z_q <= z_nxt;
                if (z_nxt == seed_q) begin
                    wrap_q <= 1'b1;
                    cnt_q  <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_ONE;
                end
            end
        end
    end

    assign bus.seed_ready = (state_q == S_IDLE);
    assign bus.out_valid  = (state_q != S_IDLE);
    assign bus.out_data   = z_q;
    assign bus.wrap       = wrap_q;
    assign bus.step_cnt   = cnt_q;
    assign bus.seed_err   = err_q;
    assign bus.fsm_state  = state_q;

endmodule

// File: tb/tb_lfsr_stream.sv
// Bench for lfsr_stream: a Fibonacci and a Galois instance (N=8) driven in lockstep,
// with a per-beat expected queue fed by independent next-state models.
module tb_lfsr_stream;
    import lfsr_pkg::*;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] seed_data;
    logic       seed_valid;
    logic       start;
    logic       stop;
    logic       out_ready;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] gexp_q[$];
    logic [7:0] model;

    lfsr_stream_if #(.N(N)) fbus ();
    lfsr_stream_if #(.N(N)) gbus ();

    assign fbus.seed_data  = seed_data;
    assign fbus.seed_valid = seed_valid;
    assign fbus.start      = start;
    assign fbus.stop       = stop;
    assign fbus.out_ready  = out_ready;
    assign gbus.seed_data  = seed_data;
    assign gbus.seed_valid = seed_valid;
    assign gbus.start      = start;
    assign gbus.stop       = stop;
    assign gbus.out_ready  = out_ready;

    lfsr_stream #(.N(N), .GALOIS(0)) dut_fib (.clk(clk), .rst(rst), .bus(fbus));
    lfsr_stream #(.N(N), .GALOIS(1)) dut_gal (.clk(clk), .rst(rst), .bus(gbus));

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- reference models ----------------
    // Vector bit 0 is z[8]. Fibonacci taps 8,6,5,4 -> bits 0,2,3,4.
    function automatic logic [7:0] fib_next(input logic [7:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[4], v[7:1]};
    endfunction

    // Galois: taps 6,5,4 land on z[7],z[6],z[5] -> bits 1,2,3.
    function automatic logic [7:0] gal_next(input logic [7:0] v);
        logic [7:0] r;
        r = {v[0], v[7:1]};
        if (v[0]) r = r ^ 8'h0E;
        return r;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; seed_data = '0; seed_valid = 1'b0;
        start = 1'b0; stop = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (fbus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got %b want 0", fbus.out_valid); end
        total++; if (fbus.seed_ready !== 1'b1) begin bad++; $display("FAIL reset_seed_ready got %b want 1", fbus.seed_ready); end
        total++; if (fbus.out_data !== 8'h01) begin bad++; $display("FAIL reset_out_data got %h want 01", fbus.out_data); end
        total++; if (fbus.step_cnt !== 8'h00) begin bad++; $display("FAIL reset_step_cnt got %h want 00", fbus.step_cnt); end
        total++; if (fbus.seed_err !== 1'b0) begin bad++; $display("FAIL reset_seed_err got %b want 0", fbus.seed_err); end
        total++; if (fbus.wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap got %b want 0", fbus.wrap); end
        total++; if (fbus.fsm_state !== S_IDLE) begin bad++; $display("FAIL reset_fsm got %0d want %0d", fbus.fsm_state, S_IDLE); end
        model = 8'h01;
    endtask

    task automatic test_fib_sequence();
        logic [7:0] e;
        exp_q.delete();
        exp_q.push_back(8'h01); exp_q.push_back(8'h80); exp_q.push_back(8'h40);
        exp_q.push_back(8'h20); exp_q.push_back(8'h10); exp_q.push_back(8'h88);
        start = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start = 1'b0;
            e = exp_q.pop_front();
            total++; if (fbus.out_valid !== 1'b1) begin bad++; $display("FAIL seq_valid[%0d] got %b want 1", i, fbus.out_valid); end
            total++; if (fbus.out_data !== e) begin bad++; $display("FAIL seq_data[%0d] got %h want %h", i, fbus.out_data, e); end
            if (i == 5) stop = 1'b1;
        end
        @(negedge clk);
        stop = 1'b0; out_ready = 1'b0;
        model = fib_next(8'h88);
        total++; if (fbus.out_valid !== 1'b0) begin bad++; $display("FAIL seq_stop_valid got %b want 0", fbus.out_valid); end
        total++; if (fbus.out_data !== model) begin bad++; $display("FAIL seq_stop_data got %h want %h", fbus.out_data, model); end
        total++; if (fbus.step_cnt !== 8'd6) begin bad++; $display("FAIL seq_step_cnt got %0d want 6", fbus.step_cnt); end
    endtask

    task automatic test_backpressure();
        logic [7:0] e;
        exp_q.delete();
        exp_q.push_back(model);
        start = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'b0;
            e = exp_q.pop_front();
            total++; if (fbus.out_data !== e) begin bad++; $display("FAIL bp_run[%0d] got %h want %h", i, fbus.out_data, e); end
            exp_q.push_back(fib_next(e));
        end
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++; if (fbus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid[%0d] got %b want 1", i, fbus.out_valid); end
            total++; if (fbus.out_data !== exp_q[0]) begin bad++; $display("FAIL bp_hold_data[%0d] got %h want %h", i, fbus.out_data, exp_q[0]); end
            total++; if (fbus.step_cnt !== 8'd9) begin bad++; $display("FAIL bp_hold_cnt[%0d] got %0d want 9", i, fbus.step_cnt); end
        end
        out_ready = 1'b1; stop = 1'b1;
        e = exp_q.pop_front();
        exp_q.push_back(fib_next(e));
        @(negedge clk);
        stop = 1'b0; out_ready = 1'b0;
        e = exp_q.pop_front();
        total++; if (fbus.out_data !== e) begin bad++; $display("FAIL bp_resume got %h want %h", fbus.out_data, e); end
        total++; if (fbus.step_cnt !== 8'd10) begin bad++; $display("FAIL bp_resume_cnt got %0d want 10", fbus.step_cnt); end
        total++; if (fbus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_idle_valid got %b want 0", fbus.out_valid); end
        model = e;
    endtask

    // Seed both instances with seed (start in the same cycle) and run until the wrap.
    task automatic test_wrap(input logic [7:0] seed);
        logic [7:0] e;
        logic [7:0] ge;
        logic [7:0] exp_cnt;
        bit         seen [256];
        int         beats;
        bit         done;
        beats = 0;
        done  = 1'b0;
        exp_q.delete();
        gexp_q.delete();
        exp_q.push_back(seed);
        gexp_q.push_back(seed);
        seed_data = seed; seed_valid = 1'b1; start = 1'b1; out_ready = 1'b1;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            @(negedge clk);
            seed_valid = 1'b0; start = 1'b0;
            exp_cnt = 8'(beats % 255);
            if (cyc == 0) begin
                total++; if (fbus.seed_err !== 1'b0) begin bad++; $display("FAIL wrap_seed_err got %b want 0", fbus.seed_err); end
            end
            total++; if (fbus.wrap !== (beats == 255)) begin bad++; $display("FAIL wrap_fib at beat %0d got %b want %b", beats, fbus.wrap, beats == 255); end
            total++; if (gbus.wrap !== (beats == 255)) begin bad++; $display("FAIL wrap_gal at beat %0d got %b want %b", beats, gbus.wrap, beats == 255); end
            total++; if (fbus.step_cnt !== exp_cnt) begin bad++; $display("FAIL wrap_fib_cnt at beat %0d got %0d want %0d", beats, fbus.step_cnt, exp_cnt); end
            total++; if (gbus.step_cnt !== exp_cnt) begin bad++; $display("FAIL wrap_gal_cnt at beat %0d got %0d want %0d", beats, gbus.step_cnt, exp_cnt); end
            if (beats < 255) begin
                total++; if (seen[fbus.out_data]) begin bad++; $display("FAIL wrap_repeat at beat %0d got %h want unseen", beats, fbus.out_data); end
                seen[fbus.out_data] = 1'b1;
            end
            e  = exp_q.pop_front();
            ge = gexp_q.pop_front();
            total++; if (fbus.out_data !== e) begin bad++; $display("FAIL wrap_fib_data at beat %0d got %h want %h", beats, fbus.out_data, e); end
            total++; if (gbus.out_data !== ge) begin bad++; $display("FAIL wrap_gal_data at beat %0d got %h want %h", beats, gbus.out_data, ge); end
            exp_q.push_back(fib_next(e));
            gexp_q.push_back(gal_next(ge));
            if (beats == 255) begin
                stop = 1'b1;
                done = 1'b1;
            end
            beats++;
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL wrap_timeout got %0d beats want 256", beats);
        end
        @(negedge clk);
        stop = 1'b0; out_ready = 1'b0;
        model = exp_q[0];
        total++; if (fbus.out_valid !== 1'b0) begin bad++; $display("FAIL wrap_idle_valid got %b want 0", fbus.out_valid); end
        total++; if (fbus.out_data !== model) begin bad++; $display("FAIL wrap_idle_data got %h want %h", fbus.out_data, model); end
    endtask

    task automatic test_seed_zero();
        seed_data = 8'h00; seed_valid = 1'b1;
        @(negedge clk);
        seed_valid = 1'b0;
        total++; if (fbus.out_data !== 8'h01) begin bad++; $display("FAIL zero_out_data got %h want 01", fbus.out_data); end
        total++; if (fbus.seed_err !== 1'b1) begin bad++; $display("FAIL zero_seed_err_fib got %b want 1", fbus.seed_err); end
        total++; if (gbus.seed_err !== 1'b1) begin bad++; $display("FAIL zero_seed_err_gal got %b want 1", gbus.seed_err); end
        total++; if (fbus.step_cnt !== 8'h00) begin bad++; $display("FAIL zero_step_cnt got %0d want 0", fbus.step_cnt); end
        total++; if (fbus.out_valid !== 1'b0) begin bad++; $display("FAIL zero_out_valid got %b want 0", fbus.out_valid); end
        test_wrap(8'hA5);
    endtask

    task automatic test_stop();
        out_ready = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b1;
        total++; if (fbus.out_valid !== 1'b1) begin bad++; $display("FAIL stop_run_valid got %b want 1", fbus.out_valid); end
        total++; if (fbus.out_data !== model) begin bad++; $display("FAIL stop_run_data got %h want %h", fbus.out_data, model); end
        @(negedge clk);
        total++; if (fbus.fsm_state !== S_STOP) begin bad++; $display("FAIL stop_state got %0d want %0d", fbus.fsm_state, S_STOP); end
        total++; if (fbus.out_valid !== 1'b1) begin bad++; $display("FAIL stop_valid got %b want 1", fbus.out_valid); end
        total++; if (fbus.seed_ready !== 1'b0) begin bad++; $display("FAIL stop_seed_ready got %b want 0", fbus.seed_ready); end
        start = 1'b1; stop = 1'b1; seed_data = 8'h3C; seed_valid = 1'b1;
        @(negedge clk);
        total++; if (fbus.fsm_state !== S_STOP) begin bad++; $display("FAIL stop_ignore_state got %0d want %0d", fbus.fsm_state, S_STOP); end
        total++; if (fbus.out_data !== model) begin bad++; $display("FAIL stop_ignore_data got %h want %h", fbus.out_data, model); end
        start = 1'b0; stop = 1'b0; seed_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        model = fib_next(model);
        total++; if (fbus.fsm_state !== S_IDLE) begin bad++; $display("FAIL stop_exit_state got %0d want %0d", fbus.fsm_state, S_IDLE); end
        total++; if (fbus.out_valid !== 1'b0) begin bad++; $display("FAIL stop_exit_valid got %b want 0", fbus.out_valid); end
        total++; if (fbus.seed_ready !== 1'b1) begin bad++; $display("FAIL stop_exit_seed_ready got %b want 1", fbus.seed_ready); end
        total++; if (fbus.out_data !== model) begin bad++; $display("FAIL stop_exit_data got %h want %h", fbus.out_data, model); end
        stop = 1'b1;
        @(negedge clk);
        total++; if (fbus.fsm_state !== S_IDLE) begin bad++; $display("FAIL idle_stop_state got %0d want %0d", fbus.fsm_state, S_IDLE); end
        total++; if (fbus.out_data !== model) begin bad++; $display("FAIL idle_stop_data got %h want %h", fbus.out_data, model); end
        stop = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++; if (fbus.out_valid !== 1'b1) begin bad++; $display("FAIL resume_valid got %b want 1", fbus.out_valid); end
        total++; if (fbus.out_data !== model) begin bad++; $display("FAIL resume_data got %h want %h", fbus.out_data, model); end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0; out_ready = 1'b0;
        model = fib_next(model);
        total++; if (fbus.fsm_state !== S_IDLE) begin bad++; $display("FAIL run_stop_state got %0d want %0d", fbus.fsm_state, S_IDLE); end
        total++; if (fbus.out_data !== model) begin bad++; $display("FAIL run_stop_data got %h want %h", fbus.out_data, model); end
    endtask

    task automatic test_reset_mid_run();
        start = 1'b1; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        total++; if (fbus.out_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid got %b want 1", fbus.out_valid); end
        #2 rst = 1'b1;
        #1;
        total++; if (fbus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got %b want 0", fbus.out_valid); end
        total++; if (fbus.seed_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_seed_ready got %b want 1", fbus.seed_ready); end
        total++; if (fbus.out_data !== 8'h01) begin bad++; $display("FAIL mid_rst_data got %h want 01", fbus.out_data); end
        total++; if (gbus.out_data !== 8'h01) begin bad++; $display("FAIL mid_rst_gal_data got %h want 01", gbus.out_data); end
        total++; if (fbus.step_cnt !== 8'h00) begin bad++; $display("FAIL mid_rst_cnt got %0d want 0", fbus.step_cnt); end
        total++; if (fbus.wrap !== 1'b0) begin bad++; $display("FAIL mid_rst_wrap got %b want 0", fbus.wrap); end
        total++; if (fbus.fsm_state !== S_IDLE) begin bad++; $display("FAIL mid_rst_state got %0d want %0d", fbus.fsm_state, S_IDLE); end
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_fib_sequence();
        test_backpressure();
        test_wrap(8'h01);
        test_seed_zero();
        test_stop();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
